// File: rtl/makestuff_ram_arb.sv
// makestuff_ram_arb
// Two-requester round-robin front end for a simple dual-port RAM with a
// registered read port (one cycle of read latency). After reset, and whenever
// clear_in is pulsed while running, the block sweeps every row and writes
// zeros before it accepts any traffic.
//
// Ports
//   clk_in, rstn_in          : clock (rising edge) and async active-low reset
//   clear_in                 : pulse while running to re-zero the whole RAM
//   initDone_out             : high while in the RUN state
//   reqValid_in/reqReady_out : per-requester handshake (ready is combinational)
//   reqWrite_in              : 1 = write, 0 = read
//   reqAddr_in/Mask/Data     : per-requester row address, span enables, data
//   rspValid_out/rspData_out : read response, one cycle after the read grant
//   ramWr*_out               : RAM write port (mask, address, data)
//   ramRdAddr_out            : RAM read address
//   ramRdData_in             : RAM read data, registered inside the RAM
module makestuff_ram_arb #(
    parameter int ADDR_NBITS = 5,
    parameter int SPAN_NBITS = 8,
    parameter int NUM_SPANS  = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rstn_in,
    input  logic                                  clear_in,
    output logic                                  initDone_out,
    input  logic [1:0]                            reqValid_in,
    output logic [1:0]                            reqReady_out,
    input  logic [1:0]                            reqWrite_in,
    input  logic [1:0][ADDR_NBITS-1:0]            reqAddr_in,
    input  logic [1:0][NUM_SPANS-1:0]             reqMask_in,
    input  logic [1:0][NUM_SPANS*SPAN_NBITS-1:0]  reqData_in,
    output logic [1:0]                            rspValid_out,
    output logic [NUM_SPANS*SPAN_NBITS-1:0]       rspData_out,
    output logic [NUM_SPANS-1:0]                  ramWrMask_out,
    output logic [ADDR_NBITS-1:0]                 ramWrAddr_out,
    output logic [NUM_SPANS*SPAN_NBITS-1:0]       ramWrData_out,
    output logic [ADDR_NBITS-1:0]                 ramRdAddr_out,
    input  logic [NUM_SPANS*SPAN_NBITS-1:0]       ramRdData_in
);

    localparam int DATA_NBITS = NUM_SPANS * SPAN_NBITS;
    localparam logic [ADDR_NBITS-1:0] LAST_ROW = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_NBITS-1:0]   count_q, count_d;
    logic                    lastGrant_q, lastGrant_d;
    logic [1:0]              rspValid_q, rspValid_d;
    logic [1:0]              grant;
    logic                    grantSel;

    // State register. lastGrant_q holds the index of the most recently granted
    // requester; resetting it to 1 makes requester 0 win the first contention.
    // Clearing rspValid_q here is what drops an in-flight read on reset.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q     <= S_CLEAR;
            count_q     <= '0;
            lastGrant_q <= 1'b1;
            rspValid_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lastGrant_q <= lastGrant_d;
            rspValid_q  <= rspValid_d;
        end
    end

    // Round-robin grant. Nothing is granted while clearing or in the cycle
    // clear_in is seen, so no transfer can race the sweep.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_RUN && !clear_in) begin
            unique case (reqValid_in)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = lastGrant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Next-state and RAM-port decode. During the sweep the write mask is
    // qualified by rstn_in so the RAM sees no write while reset is held, even
    // though the state register already reads CLEAR.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        lastGrant_d   = lastGrant_q;
        rspValid_d    = 2'b00;
        ramWrMask_out = '0;
        ramWrAddr_out = '0;
        ramWrData_out = '0;
        ramRdAddr_out = '0;
        grantSel      = grant[1];

        if (state_q == S_CLEAR) begin
            ramWrMask_out = rstn_in ? '1 : '0;
            ramWrAddr_out = count_q;
            ramWrData_out = '0;
            count_d       = count_q + 1'b1;
            if (count_q == LAST_ROW) begin
                state_d = S_RUN;
                count_d = '0;
            end
        end else begin
            if (clear_in) begin
                state_d = S_CLEAR;
                count_d = '0;
            end
            if (grant != 2'b00) begin
                lastGrant_d = grantSel;
                if (reqWrite_in[grantSel]) begin
                    ramWrMask_out = reqMask_in[grantSel];
                    ramWrAddr_out = reqAddr_in[grantSel];
                    ramWrData_out = reqData_in[grantSel];
                end else begin
                    ramRdAddr_out        = reqAddr_in[grantSel];
                    rspValid_d[grantSel] = 1'b1;
                end
            end
        end
    end

    // The RAM's read register lines up with rspValid_q, so read data is passed
    // straight through; it is forced to zero when no response is pending.
    always_comb begin
        reqReady_out = grant;
        initDone_out = (state_q == S_RUN);
        rspValid_out = rspValid_q;
        rspData_out  = (rspValid_q != 2'b00) ? ramRdData_in : {DATA_NBITS{1'b0}};
    end

endmodule

// File: doc/makestuff_ram_arb.md
MAKESTUFF_RAM_ARB -- requirements
Module: makestuff_ram_arb

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- ADDR_NBITS, 5, RAM row-address width (2**ADDR_NBITS rows).
- SPAN_NBITS, 8, bits per span (byte lane).
- NUM_SPANS, 8, spans per row (byte-enables).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_in, in, 1, single clock; all logic on its rising edge.
- rstn_in, in, 1, asynchronous active-low reset.
- clear_in, in, 1, pulse in RUN: re-zero the whole RAM.
- initDone_out, out, 1, high in RUN state.
- reqValid_in, in, [1:0], per-requester request valid.
- reqReady_out, out, [1:0], per-requester grant (combinational).
- reqWrite_in, in, [1:0], 1=write, 0=read.
- reqAddr_in, in, [1:0][ADDR_NBITS-1:0], row address.
- reqMask_in, in, [1:0][NUM_SPANS-1:0], write span enables.
- reqData_in, in, [1:0][NUM_SPANS*SPAN_NBITS-1:0], write data.
- rspValid_out, out, [1:0], read data valid.
- rspData_out, out, [NUM_SPANS*SPAN_NBITS-1:0], read data (shared).
- ramWrMask_out, out, NUM_SPANS, to RAM write mask.
- ramWrAddr_out, out, ADDR_NBITS, to RAM write address.
- ramWrData_out, out, NUM_SPANS*SPAN_NBITS, to RAM write data.
- ramRdAddr_out, out, ADDR_NBITS, to RAM read address.
- ramRdData_in, in, NUM_SPANS*SPAN_NBITS, from RAM read data (registered, 1-cycle latency).

Function
REQ-003 The FSM SHALL have two states, CLEAR and RUN; reset enters CLEAR with clear counter = 0.
REQ-004 In CLEAR, each cycle SHALL drive ramWrMask_out = all ones, ramWrAddr_out = counter, ramWrData_out = 0; the counter then increments.
REQ-005 At counter = 2**ADDR_NBITS-1, CLEAR SHALL write that row and then enter RUN; the sweep takes exactly 2**ADDR_NBITS cycles with no wrap.
REQ-006 In CLEAR, reqReady_out SHALL be 0 and initDone_out SHALL be 0.
REQ-007 In RUN, at most one reqReady_out bit SHALL be high per cycle, and only for a requester with reqValid_in high.
REQ-008 Arbitration SHALL be round-robin:
- if exactly one requester is valid, it is granted;
- if both are valid, the requester not granted most recently is granted;
- the last-grant pointer updates only on a grant;
- after reset the pointer favours requester 0.
REQ-009 A transfer SHALL occur when reqValid_in[i] and reqReady_out[i] are both high; requesters SHALL hold request fields stable until then.
REQ-010 A granted write SHALL drive ramWrMask_out/ramWrAddr_out/ramWrData_out from that requester in the same cycle; it produces no response.
REQ-011 A write with an all-zero mask SHALL be accepted, leave the RAM unchanged and produce no response.
REQ-012 A granted read SHALL drive ramRdAddr_out = reqAddr_in[i] in the same cycle.
REQ-013 One cycle after a granted read, the block SHALL assert rspValid_out[i] for one cycle with rspData_out = ramRdData_in.
REQ-014 A read granted the cycle after a write to the same row SHALL return the new data, since the write is committed at the intervening edge.
REQ-015 When no write is granted and the state is not CLEAR, ramWrMask_out SHALL be 0; when no read is granted, ramRdAddr_out SHALL be 0.
REQ-016 clear_in in RUN SHALL deny grants that cycle and enter CLEAR at the next edge.
REQ-017 A read granted in the cycle before clear_in SHALL still deliver its response.
REQ-018 clear_in SHALL be ignored while in CLEAR.
REQ-019 Back-to-back reads SHALL sustain one response per cycle; rspValid_out SHALL never have both bits high in the same cycle.

Reset
REQ-020 While rstn_in is low, the block SHALL hold:
- state = CLEAR, counter = 0, pointer favours requester 0;
- reqReady_out = 0, rspValid_out = 0, rspData_out = 0, initDone_out = 0;
- ramWrMask_out = 0, ramWrAddr_out = 0, ramWrData_out = 0, ramRdAddr_out = 0.
REQ-021 Reset asserted mid-sweep or mid-read SHALL abort the operation, drop any pending response, and restart the full sweep after deassertion.

Verification
REQ-022 The bench SHALL cover these directed scenarios (defaults: 32 rows, 8 spans of 8 bits):
- Reset release -> ramWrMask_out = 0xFF at addresses 0..31 over 32 cycles, then initDone_out = 1; a read of row 7 from requester 0 returns 0.
- Requester 0 writes row 3 with mask 0x0F and data 0x1122334455667788; requester 1 then reads row 3 -> rspValid_out[1] high one cycle after the grant, rspData_out = 0x0000000055667788.
- Both requesters hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1 and rspValid_out follows the same pattern one cycle later.
- Requester 1 reads row 5; clear_in pulses the next cycle -> requester 1's response is still delivered, 32 clear cycles follow with reqReady_out = 0, then a read of row 5 returns 0.
- rstn_in pulsed low at clear counter = 10 -> all outputs zero during reset, and the sweep restarts at address 0 after deassertion.
- Write with mask 0x00 to row 9 holding 0xAA.. -> accepted (reqReady_out high), no response, and a subsequent read of row 9 returns 0xAA...
